program_launcher: RTL and testbench
===================================

PROGRAM_LAUNCHER -- requirements
Module: program_launcher

Interface
REQ-001 Parameter REQ_CYCLES, default 2: number of clock cycles req is held high per launch; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 4095: RUN-state cycle limit before abort; legal range 1..65535.
REQ-003 clock  input  1  single clock for all state; rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  start a launch sequence; sampled only in IDLE.
REQ-006 num_progs  input  2  programs to run minus one (0 = 1 program, 3 = 4 programs); captured when go is accepted.
REQ-007 ack  input  1  core-done level from the processor core.
REQ-008 req  output  1  start request to the core; resets the core PC while high.
REQ-009 prog_sel  output  2  index of the program currently launched.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a sequence ends, whether normal or aborted.
REQ-012 timeout_err  output  1  sticky abort flag; cleared on the next accepted go.
REQ-013 cycles  output  16  RUN-cycle count of the last completed program.
REQ-014 cycles_valid  output  1  one-cycle pulse when cycles is updated.

Function
REQ-015 The FSM SHALL have the states IDLE, START, RUN, RECORD and FINISH; all outputs SHALL be registered.
REQ-016 IDLE, go=1 at edge N: from edge N, state=START, req=1, prog_sel=0, timeout_err=0, and num_progs is latched.
REQ-017 START: req SHALL stay high for exactly REQ_CYCLES cycles, then go low on entry to RUN.
REQ-018 RUN entry: run counter=0 and arm flag=0.
- arm flag sets on the first RUN cycle with ack=0.
- A qualified ack is ack=1 while arm=1.
- A stale ack that is already high on RUN entry SHALL be ignored until ack has been seen low.
REQ-019 RUN, each cycle without a qualified ack: run counter +1, saturating at 16'hFFFF.
REQ-020 Qualified ack: next state=RECORD.
- cycles = run counter value (the number of RUN cycles before the ack cycle).
- cycles_valid pulses for exactly the RECORD cycle.
REQ-021 RECORD, last program (prog_sel equals latched num_progs): next state=FINISH.
REQ-022 RECORD, otherwise: prog_sel+1 and next state=START, with req reasserted for REQ_CYCLES cycles.
REQ-023 FINISH: done=1 for one cycle, then IDLE; prog_sel and cycles SHALL hold their values in IDLE.
REQ-024 go SHALL be ignored in every state other than IDLE, including the FINISH cycle.
REQ-025 A single-cycle ack that falls within the req window SHALL be ignored, because arm is cleared on RUN entry.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE and req=0, including mid-START or mid-RUN; no done pulse SHALL be generated.
REQ-027 Reset values: prog_sel=0, busy=0, done=0, timeout_err=0, cycles=0, cycles_valid=0, run counter=0, arm=0.
REQ-028 After reset_n rises, the first go SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-029 Macro PROGRAM_LAUNCHER_TIMEOUT_EN defined:
- In RUN, when run counter reaches TIMEOUT_CYCLES without a qualified ack, timeout_err=1, req=0, next state=FINISH.
- No RECORD cycle occurs and cycles is not updated.
- The remaining programs are skipped.
REQ-030 Macro PROGRAM_LAUNCHER_TIMEOUT_EN undefined: RUN SHALL wait indefinitely, timeout_err SHALL be tied to 0, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-031 Setup REQ_CYCLES=2, num_progs=0, go pulse; ack rises 10 cycles after req falls -> req high 2 cycles, cycles=10, one cycles_valid pulse, one done pulse, busy low after FINISH.
REQ-032 Setup num_progs=2; acks after 5, 7 and 3 RUN cycles -> prog_sel steps 0,1,2; three req pulses of 2 cycles each; cycles reads 5, 7, 3; one done pulse.
REQ-033 Stale ack: ack held high through START and the first 3 RUN cycles, low 4 cycles, then high -> no early completion; cycles=7.
REQ-034 Macro defined, TIMEOUT_CYCLES=20, num_progs=1, ack never rises -> timeout_err=1 after 20 RUN cycles, done pulse, prog_sel=0, no cycles_valid; next go clears timeout_err.
REQ-035 Reset mid-RUN: reset_n low for 1 cycle, 4 cycles into RUN -> req=0, busy=0 asynchronously, no done pulse; go during START or RUN is ignored (prog_sel unchanged).

Source files
------------

// File: rtl/program_launcher.sv
// program_launcher: sequences up to four program launches on a processor core.
// For each program it pulses req for REQ_CYCLES cycles, waits in RUN for a
// qualified ack (a high ack that follows at least one low ack cycle in RUN),
// and records how many RUN cycles elapsed before that ack.
// Optional feature: define PROGRAM_LAUNCHER_TIMEOUT_EN to abort a sequence
// once a program has spent TIMEOUT_CYCLES cycles in RUN without an ack.
// Without the macro, RUN waits indefinitely and timeout_err is tied low.
module program_launcher #(
   parameter int unsigned REQ_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        go,
   input  logic [1:0]  num_progs,
   input  logic        ack,
   output logic        req,
   output logic [1:0]  prog_sel,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic [15:0] cycles,
   output logic        cycles_valid
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_RECORD = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   // Index of the last START cycle; the req window is REQ_CYCLES long.
   localparam logic [3:0] REQ_LAST = 4'(REQ_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic        req_q, req_d;
   logic [3:0]  req_cnt_q, req_cnt_d;
   logic [1:0]  prog_sel_q, prog_sel_d;
   logic [1:0]  num_q, num_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic        arm_q, arm_d;
   logic [15:0] cycles_q, cycles_d;
   logic        cycles_valid_q, cycles_valid_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        qual_ack_s;

`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
   // RUN cycle index at which the abort fires, so exactly TIMEOUT_CYCLES RUN cycles elapse.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic        timeout_err_q, timeout_err_d;
`endif

   // An ack only counts once it has been seen low during this RUN visit,
   // which filters both a stale level left over from the previous program
   // and a short ack pulse that landed inside the req window.
   assign qual_ack_s = ack & arm_q;

   // Next-state and next-output computation for the launch sequencer.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      req_cnt_d      = req_cnt_q;
      prog_sel_d     = prog_sel_q;
      num_d          = num_q;
      run_cnt_d      = run_cnt_q;
      arm_d          = arm_q;
      cycles_d       = cycles_q;
      cycles_valid_d = 1'b0;
      done_d         = 1'b0;
`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
      timeout_err_d  = timeout_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d    = S_START;
               req_d      = 1'b1;
               req_cnt_d  = 4'd0;
               prog_sel_d = 2'd0;
               num_d      = num_progs;
`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (req_cnt_q == REQ_LAST) begin
               state_d   = S_RUN;
               req_d     = 1'b0;
               run_cnt_d = 16'd0;
               arm_d     = 1'b0;
            end else begin
               req_cnt_d = req_cnt_q + 4'd1;
            end
         end
         S_RUN: begin
            if (qual_ack_s) begin
               state_d        = S_RECORD;
               cycles_d       = run_cnt_q;
               cycles_valid_d = 1'b1;
            end
`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
            else if (run_cnt_q == TIMEOUT_LAST) begin
               // Abort the whole sequence; remaining programs are skipped.
               state_d       = S_FINISH;
               done_d        = 1'b1;
               req_d         = 1'b0;
               timeout_err_d = 1'b1;
               run_cnt_d     = run_cnt_q + 16'd1;
            end
`endif
            else begin
               if (run_cnt_q != 16'hFFFF) begin
                  run_cnt_d = run_cnt_q + 16'd1;
               end else begin
                  run_cnt_d = run_cnt_q;
               end
               if (!ack) begin
                  arm_d = 1'b1;
               end else begin
                  arm_d = arm_q;
               end
            end
         end
         S_RECORD: begin
            if (prog_sel_q == num_q) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
            end else begin
               state_d    = S_START;
               prog_sel_d = prog_sel_q + 2'd1;
               req_d      = 1'b1;
               req_cnt_d  = 4'd0;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset forces IDLE with req low at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         req_q          <= 1'b0;
         req_cnt_q      <= 4'd0;
         prog_sel_q     <= 2'd0;
         num_q          <= 2'd0;
         run_cnt_q      <= 16'd0;
         arm_q          <= 1'b0;
         cycles_q       <= 16'd0;
         cycles_valid_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         req_cnt_q      <= req_cnt_d;
         prog_sel_q     <= prog_sel_d;
         num_q          <= num_d;
         run_cnt_q      <= run_cnt_d;
         arm_q          <= arm_d;
         cycles_q       <= cycles_d;
         cycles_valid_q <= cycles_valid_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
      end
   end

`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
   // Sticky abort flag, cleared only when the next go is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign req          = req_q;
   assign prog_sel     = prog_sel_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign cycles       = cycles_q;
   assign cycles_valid = cycles_valid_q;

endmodule

// File: tb/tb_program_launcher.sv
// Self-checking bench for program_launcher. A behavioural core drives ack;
// expected cycle counts go into a scoreboard queue when the ack delay is
// chosen and are compared against values captured on cycles_valid.
// Define PROGRAM_LAUNCHER_TIMEOUT_EN to also exercise the abort path.
module tb_program_launcher;

   localparam int REQ_CYC = 2;
   localparam int TMO     = 20;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        go = 1'b0;
   logic [1:0]  num_progs = 2'd0;
   logic        ack = 1'b0;
   logic        req;
   logic [1:0]  prog_sel;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [15:0] cycles;
   logic        cycles_valid;

   int total = 0;
   int bad = 0;

   int          exp_q[$];
   logic [15:0] obs_q[$];
   int          width_q[$];
   int          psel_q[$];
   int          done_cnt = 0;
   int          cv_cnt = 0;
   int          req_len = 0;

   program_launcher #(
      .REQ_CYCLES(REQ_CYC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .go(go),
      .num_progs(num_progs),
      .ack(ack),
      .req(req),
      .prog_sel(prog_sel),
      .busy(busy),
      .done(done),
      .timeout_err(timeout_err),
      .cycles(cycles),
      .cycles_valid(cycles_valid)
   );

   always #5 clock = ~clock;

   // Monitor: log cycles_valid values, done pulses, req widths and prog_sel at each req rise.
   always @(negedge clock) begin
      if (cycles_valid) begin
         obs_q.push_back(cycles);
         cv_cnt <= cv_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (req) begin
         if (req_len == 0) psel_q.push_back(int'(prog_sel));
         req_len <= req_len + 1;
      end else if (req_len != 0) begin
         width_q.push_back(req_len);
         req_len <= 0;
      end
   end

   // Behavioural core: wait for req to fall, then drive ack per cycle c of RUN
   // as (c < stale) || (c == k); the launcher should report cycles = k.
   task automatic run_prog(input int stale, input int k);
      bit seen_hi;
      bit fell;
      bit got;
      seen_hi = req;
      fell = 1'b0;
      for (int n = 0; n < 64 && !fell; n++) begin
         @(negedge clock);
         if (req) seen_hi = 1'b1;
         else if (seen_hi) fell = 1'b1;
      end
      total++;
      if (!fell) begin
         bad++;
         $display("FAIL req_fall: req=%0b, required a completed req pulse", req);
      end
      exp_q.push_back(k);
      for (int c = 0; c <= k; c++) begin
         if (c > 0) @(negedge clock);
         ack = (c < stale) || (c == k);
      end
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clock);
         if (cycles_valid) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL cv_wait: cycles_valid=%0b, required 1 within 8 cycles", cycles_valid);
      end
      ack = 1'b0;
   endtask

   task automatic wait_done(output bit found);
      found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         @(negedge clock);
         if (done) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if ({req, prog_sel, busy, done, timeout_err, cycles, cycles_valid} !== 23'd0) begin
         bad++;
         $display("FAIL reset_hold: outputs=%h required 0", {req, prog_sel, busy, done, timeout_err, cycles, cycles_valid});
      end
      reset_n = 1'b1;
      @(negedge clock);
      total++;
      if ({req, prog_sel, busy, done, timeout_err, cycles, cycles_valid} !== 23'd0) begin
         bad++;
         $display("FAIL reset_release: outputs=%h required 0", {req, prog_sel, busy, done, timeout_err, cycles, cycles_valid});
      end
   endtask

   task automatic test_single();
      int d0, c0, e, w;
      bit found;
      psel_q.delete();
      width_q.delete();
      d0 = done_cnt;
      c0 = cv_cnt;
      num_progs = 2'd0;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      total++;
      if ({req, busy, prog_sel} !== 4'b1100) begin
         bad++;
         $display("FAIL single_start: req,busy,prog_sel=%b required 1100", {req, busy, prog_sel});
      end
      run_prog(0, 10);
      wait_done(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL single_done: done never seen, required one pulse");
      end
      go = 1'b1;  // arrives during FINISH and must be ignored
      @(negedge clock);
      go = 1'b0;
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++;
         $display("FAIL single_idle: busy,done=%b required 00", {busy, done});
      end
      @(negedge clock);
      total++;
      if ({busy, req} !== 2'b00) begin
         bad++;
         $display("FAIL finish_go_ignored: busy,req=%b required 00", {busy, req});
      end
      total++;
      if (cycles !== 16'd10) begin
         bad++;
         $display("FAIL single_cycles_hold: cycles=%0d required 10", cycles);
      end
      total++;
      if ((done_cnt - d0) != 1 || (cv_cnt - c0) != 1) begin
         bad++;
         $display("FAIL single_pulses: done=%0d cycles_valid=%0d required 1 and 1", done_cnt - d0, cv_cnt - c0);
      end
      w = (width_q.size() > 0) ? width_q.pop_front() : -1;
      total++;
      if (w != REQ_CYC || width_q.size() != 0) begin
         bad++;
         $display("FAIL single_req_width: width=%0d extra=%0d required %0d and 0", w, width_q.size(), REQ_CYC);
      end
`ifndef PROGRAM_LAUNCHER_TIMEOUT_EN
      total++;
      if (timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL tie_timeout: timeout_err=%0b required 0", timeout_err);
      end
`endif
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         total++;
         if (int'(obs_q[0]) != e) begin
            bad++;
            $display("FAIL single_sb: cycles=%0d required %0d", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

   task automatic test_multi();
      int d0, c0, e, w, p;
      bit found;
      psel_q.delete();
      width_q.delete();
      d0 = done_cnt;
      c0 = cv_cnt;
      num_progs = 2'd2;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      run_prog(0, 5);
      run_prog(0, 7);
      run_prog(0, 3);
      wait_done(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL multi_done: done never seen, required one pulse");
      end
      repeat (2) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         p = (psel_q.size() > 0) ? psel_q.pop_front() : -1;
         w = (width_q.size() > 0) ? width_q.pop_front() : -1;
         total++;
         if (p != i || w != REQ_CYC) begin
            bad++;
            $display("FAIL multi_launch%0d: prog_sel=%0d width=%0d required %0d and %0d", i, p, w, i, REQ_CYC);
         end
      end
      total++;
      if ((done_cnt - d0) != 1 || (cv_cnt - c0) != 3 || psel_q.size() != 0) begin
         bad++;
         $display("FAIL multi_pulses: done=%0d cycles_valid=%0d extra_req=%0d required 1,3,0", done_cnt - d0, cv_cnt - c0, psel_q.size());
      end
      total++;
      if ({prog_sel, busy} !== 3'b100 || cycles !== 16'd3) begin
         bad++;
         $display("FAIL multi_idle_hold: prog_sel=%0d busy=%0b cycles=%0d required 2,0,3", prog_sel, busy, cycles);
      end
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         total++;
         if (int'(obs_q[0]) != e) begin
            bad++;
            $display("FAIL multi_sb: cycles=%0d required %0d", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

   task automatic test_stale_ack();
      int c0, e;
      bit found;
      c0 = cv_cnt;
      num_progs = 2'd0;
      ack = 1'b1;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      run_prog(3, 7);
      wait_done(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL stale_done: done never seen, required one pulse");
      end
      repeat (2) @(negedge clock);
      total++;
      if (cycles !== 16'd7 || (cv_cnt - c0) != 1) begin
         bad++;
         $display("FAIL stale_result: cycles=%0d valid_pulses=%0d required 7 and 1", cycles, cv_cnt - c0);
      end
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         total++;
         if (int'(obs_q[0]) != e) begin
            bad++;
            $display("FAIL stale_sb: cycles=%0d required %0d", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
   task automatic test_timeout();
      int c0, d0, n, e;
      bit fell;
      bit found;
      c0 = cv_cnt;
      d0 = done_cnt;
      num_progs = 2'd1;
      ack = 1'b0;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      fell = 1'b0;
      for (int i = 0; i < 16 && !fell; i++) begin
         @(negedge clock);
         if (!req) fell = 1'b1;
      end
      n = 0;
      found = 1'b0;
      while (!found && n < 100) begin
         @(negedge clock);
         n++;
         if (done) found = 1'b1;
      end
      total++;
      if (!fell || !found || n != TMO) begin
         bad++;
         $display("FAIL timeout_len: done after %0d RUN cycles, required %0d", n, TMO);
      end
      total++;
      if ({timeout_err, prog_sel, req} !== 4'b1000) begin
         bad++;
         $display("FAIL timeout_flags: timeout_err,prog_sel,req=%b required 1000", {timeout_err, prog_sel, req});
      end
      @(negedge clock);
      total++;
      if ({timeout_err, busy} !== 2'b10 || (cv_cnt - c0) != 0 || (done_cnt - d0) != 1) begin
         bad++;
         $display("FAIL timeout_sticky: err=%0b busy=%0b valid=%0d done=%0d required 1,0,0,1", timeout_err, busy, cv_cnt - c0, done_cnt - d0);
      end
      num_progs = 2'd0;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      total++;
      if (timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_clear: timeout_err=%0b required 0", timeout_err);
      end
      run_prog(0, 4);
      wait_done(found);
      @(negedge clock);
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         total++;
         if (int'(obs_q[0]) != e) begin
            bad++;
            $display("FAIL timeout_sb: cycles=%0d required %0d", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask
`endif

   task automatic test_reset_mid_run();
      int d0, e;
      bit fell;
      bit found;
      num_progs = 2'd1;
      ack = 1'b0;
      go = 1'b1;
      @(negedge clock);
      go = 1'b1;  // still high during START: must be ignored
      @(negedge clock);
      go = 1'b0;
      total++;
      if ({req, prog_sel} !== 3'b100) begin
         bad++;
         $display("FAIL start_go_ignored: req,prog_sel=%b required 100", {req, prog_sel});
      end
      fell = 1'b0;
      for (int i = 0; i < 16 && !fell; i++) begin
         if (!req) fell = 1'b1;
         else @(negedge clock);
      end
      repeat (4) @(negedge clock);
      go = 1'b1;  // during RUN: must be ignored
      @(negedge clock);
      go = 1'b0;
      total++;
      if ({busy, req, prog_sel} !== 4'b1000) begin
         bad++;
         $display("FAIL run_go_ignored: busy,req,prog_sel=%b required 1000", {busy, req, prog_sel});
      end
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({req, busy} !== 2'b00) begin
         bad++;
         $display("FAIL async_reset: req,busy=%b required 00", {req, busy});
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      total++;
      if ((done_cnt - d0) != 0 || busy !== 1'b0 || prog_sel !== 2'd0 || cycles !== 16'd0) begin
         bad++;
         $display("FAIL reset_aftermath: done=%0d busy=%0b prog_sel=%0d cycles=%0d required 0,0,0,0", done_cnt - d0, busy, prog_sel, cycles);
      end
      num_progs = 2'd0;
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
      run_prog(0, 2);
      wait_done(found);
      total++;
      if (!found) begin
         bad++;
         $display("FAIL post_reset_done: done never seen, required one pulse");
      end
      @(negedge clock);
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         total++;
         if (int'(obs_q[0]) != e) begin
            bad++;
            $display("FAIL post_reset_sb: cycles=%0d required %0d", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_stale_ack();
`ifdef PROGRAM_LAUNCHER_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_run();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: %0d expected results never produced, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
